rect_draw_engine: RTL and testbench

// - Parametrised per-frame rasteriser: on each frame tick, clears the back buffer, then fills N_OBJ clipped rectangles (platforms, doodle box, HUD).
// - Emits a pixel-write stream (draw_x/draw_y/draw_color) into the double-buffered framebuffer, then pulses swap_req.
// - Sits between the game logic (doodle/platform) and framebuffer2.

---
 rtl/rect_draw_engine.sv | 217 +++++++++++++++++++++
 tb/tb_rect_draw_engine.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rect_draw_engine.sv
// rtl/rect_draw_engine.sv - per-frame rectangle rasteriser: clear, clipped slot fills, swap request.
// Optional column border before swap when RECT_DRAW_BORDER_EN is defined.
module rect_draw_engine #(
   parameter int W                        = 320,
   parameter int H                        = 240,
   parameter int N_OBJ                    = 8,
   parameter int DW                       = 8,
   parameter int XW                       = 10,
   parameter int X_MIN                    = 70,
   parameter int X_MAX                    = 249,
   parameter logic [DW-1:0] BG_COLOR      = 8'h00,
   parameter logic [DW-1:0] BORDER_COLOR  = 8'hFF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              frame_clk,
   input  logic [N_OBJ-1:0]  obj_valid,
   input  logic [XW-1:0]     obj_x     [N_OBJ],
   input  logic [XW-1:0]     obj_y     [N_OBJ],
   input  logic [XW-1:0]     obj_w     [N_OBJ],
   input  logic [XW-1:0]     obj_h     [N_OBJ],
   input  logic [DW-1:0]     obj_color [N_OBJ],
   input  logic              wr_ready,
   output logic              wr_en,
   output logic [XW-1:0]     draw_x,
   output logic [XW-1:0]     draw_y,
   output logic [DW-1:0]     draw_color,
   output logic              swap_req,
   output logic              busy,
   output logic [7:0]        overrun_cnt
);
   localparam int SW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
   localparam logic [XW:0] XMIN_E = (XW+1)'(X_MIN);
   localparam logic [XW:0] XMAX_E = (XW+1)'(X_MAX);
   localparam logic [XW:0] H_E    = (XW+1)'(H);
   localparam logic [XW:0] HM1_E  = (XW+1)'(H-1);

`ifdef RECT_DRAW_BORDER_EN
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_DRAW, S_BORDER, S_DONE} state_t;
   localparam state_t S_AFTER = S_BORDER;
   logic border_phase;
`else
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_DRAW, S_DONE} state_t;
   localparam state_t S_AFTER = S_DONE;
`endif

   state_t state, state_next;
   logic sync1, sync2, sync3, tick;
   logic [SW-1:0] slot;
   logic [XW-1:0] x0r, x1r;
   logic [N_OBJ-1:0] snap_v;
   logic [XW-1:0] snap_x [N_OBJ];
   logic [XW-1:0] snap_y [N_OBJ];
   logic [XW-1:0] snap_w [N_OBJ];
   logic [XW-1:0] snap_h [N_OBJ];
   logic [DW-1:0] snap_c [N_OBJ];
   logic [XW-1:0] y1r;
   logic [XW:0] xs, xe, ys, ye, cx0, cx1, cy1;
   logic skip, xfer, last_clear, last_rect, last_slot, enter_after;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= frame_clk;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end
   assign tick = sync2 & ~sync3;

   // Slot bounds are evaluated one bit wider so x+w-1 cannot wrap.
   always_comb begin
      xs   = {1'b0, snap_x[slot]};
      ys   = {1'b0, snap_y[slot]};
      xe   = xs + {1'b0, snap_w[slot]} - (XW+1)'(1);
      ye   = ys + {1'b0, snap_h[slot]} - (XW+1)'(1);
      cx0  = (xs < XMIN_E) ? XMIN_E : xs;
      cx1  = (xe > XMAX_E) ? XMAX_E : xe;
      cy1  = (ye > HM1_E) ? HM1_E : ye;
      skip = !snap_v[slot] || (snap_w[slot] == '0) || (snap_h[slot] == '0) ||
             (cx0 > cx1) || (ys >= H_E);
   end

   assign xfer        = wr_en & wr_ready;
   assign last_clear  = (draw_x == XW'(W-1)) && (draw_y == XW'(H-1));
   assign last_rect   = (draw_x == x1r) && (draw_y == y1r);
   assign last_slot   = (slot == SW'(N_OBJ-1));
   assign enter_after = ((state == S_LOAD) && skip && last_slot) ||
                        ((state == S_DRAW) && xfer && last_rect && last_slot);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      swap_req   = 1'b0;
      busy       = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (tick) state_next = S_CLEAR;
         end
         S_CLEAR: if (xfer && last_clear) state_next = S_LOAD;
         S_LOAD: begin
            if (!skip)          state_next = S_DRAW;
            else if (last_slot) state_next = S_AFTER;
         end
         S_DRAW: if (xfer && last_rect) state_next = last_slot ? S_AFTER : S_LOAD;
`ifdef RECT_DRAW_BORDER_EN
         S_BORDER: if (xfer && border_phase && (draw_y == XW'(H-1))) state_next = S_DONE;
`endif
         S_DONE: begin
            swap_req   = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Snapshot is taken on the IDLE->CLEAR transition only.
   always_ff @(posedge Clk) begin
      if (state == S_IDLE && tick) begin
         snap_v <= obj_valid;
         snap_x <= obj_x;
         snap_y <= obj_y;
         snap_w <= obj_w;
         snap_h <= obj_h;
         snap_c <= obj_color;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wr_en       <= 1'b0;
         draw_x      <= '0;
         draw_y      <= '0;
         draw_color  <= '0;
         overrun_cnt <= '0;
         slot        <= '0;
         x0r         <= '0;
         x1r         <= '0;
         y1r         <= '0;
`ifdef RECT_DRAW_BORDER_EN
         border_phase <= 1'b0;
`endif
      end else begin
         if (tick && state != S_IDLE && overrun_cnt != 8'hFF)
            overrun_cnt <= overrun_cnt + 8'd1;
         case (state)
            S_IDLE: if (tick) begin
               wr_en      <= 1'b1;
               draw_x     <= '0;
               draw_y     <= '0;
               draw_color <= BG_COLOR;
               slot       <= '0;
            end
            S_CLEAR: if (xfer) begin
               if (last_clear) wr_en <= 1'b0;
               else if (draw_x == XW'(W-1)) begin
                  draw_x <= '0;
                  draw_y <= draw_y + XW'(1);
               end else draw_x <= draw_x + XW'(1);
            end
            S_LOAD: begin
               if (skip) begin
                  if (!last_slot) slot <= slot + SW'(1);
               end else begin
                  x0r        <= cx0[XW-1:0];
                  x1r        <= cx1[XW-1:0];
                  y1r        <= cy1[XW-1:0];
                  draw_x     <= cx0[XW-1:0];
                  draw_y     <= ys[XW-1:0];
                  draw_color <= snap_c[slot];
                  wr_en      <= 1'b1;
               end
            end
            S_DRAW: if (xfer) begin
               if (last_rect) begin
                  wr_en <= 1'b0;
                  if (!last_slot) slot <= slot + SW'(1);
               end else if (draw_x == x1r) begin
                  draw_x <= x0r;
                  draw_y <= draw_y + XW'(1);
               end else draw_x <= draw_x + XW'(1);
            end
`ifdef RECT_DRAW_BORDER_EN
            S_BORDER: if (xfer) begin
               if (draw_y == XW'(H-1)) begin
                  if (!border_phase) begin
                     border_phase <= 1'b1;
                     draw_x       <= XW'(X_MAX);
                     draw_y       <= '0;
                  end else wr_en <= 1'b0;
               end else draw_y <= draw_y + XW'(1);
            end
`endif
            default: ;
         endcase
`ifdef RECT_DRAW_BORDER_EN
         if (enter_after) begin
            wr_en        <= 1'b1;
            draw_x       <= XW'(X_MIN);
            draw_y       <= '0;
            draw_color   <= BORDER_COLOR;
            border_phase <= 1'b0;
         end
`else
         if (enter_after) wr_en <= 1'b0;
`endif
      end
   end
endmodule

// File: tb/tb_rect_draw_engine.sv
// tb/tb_rect_draw_engine.sv - scoreboard bench for rect_draw_engine (W=16, H=8, N_OBJ=4).
module tb_rect_draw_engine;
   localparam int W = 16, H = 8, N = 4, XW = 10, DW = 8, XMIN = 2, XMAX = 13;

   logic clk = 1'b0;
   logic rst_n, frame_clk, wr_ready;
   logic [N-1:0] ov;
   logic [XW-1:0] ox [N];
   logic [XW-1:0] oy [N];
   logic [XW-1:0] ow [N];
   logic [XW-1:0] oh [N];
   logic [DW-1:0] oc [N];
   logic wr_en, swap_req, busy;
   logic [XW-1:0] draw_x, draw_y;
   logic [DW-1:0] draw_color;
   logic [7:0] overrun_cnt;

   int checks = 0, failures = 0;
   int xfer_cnt = 0, swap_cnt = 0, n_exp;
   logic prev_swap = 1'b0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   rect_draw_engine #(.W(W), .H(H), .N_OBJ(N), .DW(DW), .XW(XW), .X_MIN(XMIN), .X_MAX(XMAX)) dut (
      .Clk(clk), .Reset(rst_n), .frame_clk(frame_clk), .obj_valid(ov),
      .obj_x(ox), .obj_y(oy), .obj_w(ow), .obj_h(oh), .obj_color(oc),
      .wr_ready(wr_ready), .wr_en(wr_en), .draw_x(draw_x), .draw_y(draw_y),
      .draw_color(draw_color), .swap_req(swap_req), .busy(busy), .overrun_cnt(overrun_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pack(input int x, input int y, input int c);
      return {4'h0, 10'(x), 10'(y), 8'(c)};
   endfunction

   always @(negedge clk) begin
      if (prev_swap) check("busy_after_swap", 32'(busy), 32'd0);
      prev_swap = swap_req;
      if (swap_req) swap_cnt++;
      if (wr_en && wr_ready) begin
         xfer_cnt++;
         if (exp_q.size() == 0) check("extra_write", 32'd1, 32'd0);
         else check("pixel", {4'h0, draw_x, draw_y, draw_color}, exp_q.pop_front());
      end
   end

   task automatic push_frame();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) exp_q.push_back(pack(x, y, 0));
      for (int i = 0; i < N; i++)
         if (ov[i])
            for (int y = 0; y < H; y++)
               for (int x = 0; x < W; x++)
                  if (x >= int'(ox[i]) && x < int'(ox[i]) + int'(ow[i]) &&
                      y >= int'(oy[i]) && y < int'(oy[i]) + int'(oh[i]) &&
                      x >= XMIN && x <= XMAX)
                     exp_q.push_back(pack(x, y, int'(oc[i])));
`ifdef RECT_DRAW_BORDER_EN
      for (int y = 0; y < H; y++) exp_q.push_back(pack(XMIN, y, 8'hFF));
      for (int y = 0; y < H; y++) exp_q.push_back(pack(XMAX, y, 8'hFF));
`endif
      n_exp = exp_q.size();
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic fire();
      frame_clk = 1'b1;
      cyc(4);
      frame_clk = 1'b0;
   endtask

   task automatic wait_swap(input int target);
      int k = 0;
      while (swap_cnt < target && k < 3000) begin
         cyc(1);
         k++;
      end
      check("swap_timeout", 32'(swap_cnt >= target), 32'd1);
   endtask

   task automatic wait_xfers(input int target);
      int k = 0;
      while (xfer_cnt < target && k < 3000) begin
         cyc(1);
         k++;
      end
      check("xfer_timeout", 32'(xfer_cnt >= target), 32'd1);
   endtask

   task automatic set_obj(input int i, input int x, input int y, input int w, input int h,
                          input int c, input logic v);
      ox[i] = 10'(x); oy[i] = 10'(y); ow[i] = 10'(w); oh[i] = 10'(h); oc[i] = 8'(c); ov[i] = v;
   endtask

   initial begin
      rst_n = 1'b0; frame_clk = 1'b0; wr_ready = 1'b1;
      for (int i = 0; i < N; i++) set_obj(i, 0, 0, 0, 0, 0, 1'b0);
      cyc(3);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_swap", 32'(swap_req), 32'd0);
      check("rst_overrun", 32'(overrun_cnt), 32'd0);
      check("rst_draw_x", 32'(draw_x), 32'd0);
      check("rst_draw_y", 32'(draw_y), 32'd0);
      check("rst_color", 32'(draw_color), 32'd0);
      rst_n = 1'b1;
      cyc(5);
      check("idle_busy", 32'(busy), 32'd0);

      // Frame 1: clear only
      xfer_cnt = 0;
      push_frame();
      fire();
      wait_swap(1);
      cyc(3);
      check("f1_xfers", 32'(xfer_cnt), 32'(n_exp));
      check("f1_queue", 32'(exp_q.size()), 32'd0);
      check("f1_busy", 32'(busy), 32'd0);

      // Frame 2: clipping, empty slots, backpressure mid-clear
      set_obj(0, 4, 2, 3, 2, 8'h55, 1'b1);
      set_obj(1, 12, 6, 5, 4, 8'h33, 1'b1);
      set_obj(2, 5, 5, 0, 3, 8'h77, 1'b1);
      set_obj(3, 0, 0, 2, 8, 8'h99, 1'b1);
      xfer_cnt = 0;
      push_frame();
      fire();
      wait_xfers(20);
      wr_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("stall_wr_en", 32'(wr_en), 32'd1);
         check("stall_xy", {12'h0, draw_x, draw_y}, {12'h0, 10'd4, 10'd1});
         check("stall_color", 32'(draw_color), 32'd0);
      end
      @(posedge clk);
      #1 wr_ready = 1'b1;
      wait_swap(2);
      cyc(3);
      check("f2_xfers", 32'(xfer_cnt), 32'(n_exp));
      check("f2_queue", 32'(exp_q.size()), 32'd0);

      // Frame 3: overlap painter order, overrun tick and mid-frame input change
      set_obj(2, 6, 0, 2, 2, 8'h44, 1'b0);
      set_obj(3, 3, 1, 4, 3, 8'hAA, 1'b1);
      xfer_cnt = 0;
      push_frame();
      fire();
      wait_xfers(131);
      oc[0] = 8'h11;
      ox[0] = 10'd0;
      fire();
      wait_swap(3);
      cyc(40);
      check("f3_swaps", 32'(swap_cnt), 32'd3);
      check("f3_overrun", 32'(overrun_cnt), 32'd1);
      check("f3_busy", 32'(busy), 32'd0);
      check("f3_xfers", 32'(xfer_cnt), 32'(n_exp));
      check("f3_queue", 32'(exp_q.size()), 32'd0);

      // Frame 4: asynchronous reset during DRAW
      set_obj(0, 4, 2, 3, 2, 8'h55, 1'b1);
      xfer_cnt = 0;
      push_frame();
      fire();
      wait_xfers(131);
      #2 rst_n = 1'b0;
      #1;
      check("arst_wr_en", 32'(wr_en), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_swap", 32'(swap_req), 32'd0);
      check("arst_overrun", 32'(overrun_cnt), 32'd0);
      exp_q.delete();
      xfer_cnt = 0;
      cyc(2);
      rst_n = 1'b1;
      cyc(40);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_xfers", 32'(xfer_cnt), 32'd0);
      check("post_rst_swaps", 32'(swap_cnt), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
